// File: rtl/axi_burst_read_engine.sv
// AXI4 read master: splits a (start address, beat count) command into INCR
// bursts capped at MAX_BURST beats that never cross a 4 KB page.
module axi_burst_read_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int XFER_W    = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [XFER_W-1:0] cmd_beats,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic              RLAST,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [XFER_W-1:0] beat_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XFER_W-1:0] rem_q, rem_d;
  logic [XFER_W-1:0] beat_q, beat_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [8:0]        bcnt_q, bcnt_d;
  logic [1:0]        err_q, err_d;
  logic              beat_ok, burst_end;

  // min(remaining, MAX_BURST, beats left before the next 4 KB page), minus one
  function automatic logic [7:0] calc_arlen(input logic [ADDR_W-1:0] a,
                                            input logic [XFER_W-1:0] r);
    logic [12:0] page_beats;
    logic [31:0] n;
    page_beats = (13'h1000 - {1'b0, a[11:0]}) >> SZ;
    n = MAX_BURST;
    if (32'(page_beats) < n) n = 32'(page_beats);
    if (32'(r) < n) n = 32'(r);
    return 8'(n - 32'd1);
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    arlen_d   = arlen_q;
    bcnt_d    = bcnt_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    beat_ok   = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET) begin
          addr_d = cmd_addr & ALIGN;
          rem_d  = cmd_beats;
          err_d  = '0;
          beat_d = '0;
          if (cmd_beats == '0) begin
            state_d = DONE;
          end else begin
            state_d = ADDR;
            arlen_d = calc_arlen(cmd_addr & ALIGN, cmd_beats);
          end
        end
      end
      ADDR: begin
        ARVALID = 1'b1;
        busy    = 1'b1;
        if (ARREADY) begin
          state_d = DATA;
          bcnt_d  = {1'b0, arlen_q} + 9'd1;
        end
      end
      DATA: begin
        // Zero-latency pass-through: the downstream consumer back-pressures R directly
        busy      = 1'b1;
        RREADY    = out_ready;
        out_valid = RVALID;
        out_last  = RVALID && (rem_q == XFER_W'(1));
        beat_ok   = RVALID && out_ready;
        burst_end = (bcnt_q == 9'd1);
        if (beat_ok) begin
          beat_d = beat_q + XFER_W'(1);
          rem_d  = rem_q - XFER_W'(1);
          bcnt_d = bcnt_q - 9'd1;
          if (RRESP != 2'b00) err_d[0] = 1'b1;
          if (RLAST != burst_end) err_d[1] = 1'b1;
          if (burst_end) begin
            addr_d = addr_q + ((ADDR_W'(arlen_q) + ADDR_W'(1)) << SZ);
            if (rem_q == XFER_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d = ADDR;
              arlen_d = calc_arlen(addr_d, rem_d);
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      arlen_q <= '0;
      bcnt_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      arlen_q <= arlen_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  assign ARADDR     = addr_q;
  assign ARLEN      = arlen_q;
  assign ARSIZE     = 3'(SZ);
  assign ARBURST    = 2'b01;
  assign out_data   = RDATA;
  assign err        = err_q;
  assign beat_count = beat_q;

endmodule
